exec_units: RTL and testbench
=============================

# exec_units

Parametrised execute stage. It takes issued reservation-station entries on N_ALU independent ALU lanes and one memory lane, computes results, and returns them with the entry tag. ALU lanes are single-cycle and fully pipelined. The memory lane owns the data memory and runs a small FSM with configurable load latency and a valid/ready handshake. It sits between the reservation stations and the common data bus / reorder-buffer writeback.

## Interface
Parameters:
- N_ALU, 2, number of ALU lanes (1..8)
- XLEN, 32, datapath width
- MEM_DEPTH, 64, data memory words (power of two)
- MEM_LAT, 2, load latency in cycles (1..8)
- TAG_W, 4, width of the result tag

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous squash of all in-flight work
- alu_valid  in  N_ALU  lane i issues this cycle
- alu_entry  in  N_ALU x issue_entry_t  opcode, alu_op, source_1, source_2, imm, tag
- alu_res_valid  out  N_ALU  result valid
- alu_res_val  out  N_ALU x XLEN  result value
- alu_res_tag  out  N_ALU x TAG_W  tag of the result
- alu_res_err  out  N_ALU  illegal opcode/alu_op
- mem_valid  in  1  memory op offered
- mem_ready  out  1  memory lane can accept
- mem_entry  in  issue_entry_t  LW/SW entry
- mem_res_valid, mem_res_val[XLEN], mem_res_tag[TAG_W], mem_res_err, mem_res_store  out  memory result
- busy  out  N_ALU+1  bit i is the ALU lane i result valid; top bit is the memory lane not idle

## Operation
- ALU decode. Opcode 0110011: alu_op 000 ADD, 001 SUB, 010 XOR, 011 SRA. Opcode 0010011: alu_op 000 ADDI, 100 ANDI.
- Arithmetic is modulo 2^XLEN.
- SRA is an arithmetic right shift of signed source_1 by source_2[$clog2(XLEN)-1:0].
- I-type operations use imm, already sign-extended to XLEN.
- Any other opcode/alu_op combination gives a result with err=1 and val=0. The tag is still returned.
- Memory address is word index addr = source_1 + imm (XLEN bits).
  - An address is in range when addr < MEM_DEPTH.
  - Out of range gives err=1, val=0, and no write.
- LW (0000011): returns mem[addr]. Read data is snapshotted at accept.
- SW (0100011): writes source_2 to mem[addr] at the accept edge. The result is val=addr with mem_res_store=1.
- Any other memory-lane opcode returns err=1 with no write.
- Memory FSM:
  - IDLE: mem_ready=1.
  - Accept (mem_valid & mem_ready):
    - A store, or a load with MEM_LAT==1, goes to DONE.
    - Otherwise a load goes to WAIT with cnt=MEM_LAT-2.
  - WAIT: when cnt==0, go to DONE; else decrement cnt.
  - DONE: mem_res_valid=1 for this cycle only, then go to IDLE.
  - mem_ready is 0 in WAIT and DONE. A mem_valid held high is accepted on the first IDLE cycle.
- flush:
  - Clears all res_valid outputs at the next edge.
  - Forces the FSM to IDLE.
  - Blocks acceptance on the same edge.
  - A store already written stays written.
- Data memory resets to all zeros.

## Timing
- ALU: an entry issued with alu_valid at edge t has its result registered at edge t. alu_res_valid is high during cycle t+1, one cycle per issue. Back-to-back issue gives back-to-back results. Latency is 1.
- Load accepted at edge t: mem_res_valid is high exactly in cycle t+MEM_LAT.
- Store accepted at edge t: the write is visible to a load accepted at edge ≥ t+1. mem_res_valid is high in cycle t+1.
- Throughput: one store per 2 cycles; one load per MEM_LAT+1 cycles.
- Reset (asynchronous, any time, including mid-load):
  - All res_valid, val, tag, err, busy are 0.
  - FSM goes to IDLE, cnt=0, memory is zeroed.
  - mem_ready is 1 after deassertion.
- flush and reset take priority over accept. reset takes priority over flush.

## Structure
- Shared package holds:
  - issue_entry_t
  - opcode constants OP_R=0110011, OP_I=0010011, OP_LW=0000011, OP_SW=0100011
  - alu_op constants
  - the mem_state_e enum (IDLE, WAIT, DONE)
- Sub-module alu_lane: combinational decode/compute plus output register, instantiated N_ALU times via generate.
- The memory FSM and array live in the top.

## Test plan
- Reset, then ALU lane 0 issues ADD 5+7 tag 3 → cycle after: res_valid=1, val=12, tag=3, err=0. Next cycle res_valid=0.
- Lanes 0/1 in the same cycle: SRA 0x80000000 by 4 → 0xF8000000; ANDI 0xFF & 0x0F → 0x0F. Opcode 1111111 → err=1, val=0.
- SW source_2=0xDEADBEEF, source_1=10, imm=2 → mem_res_valid after 1 cycle, val=12, store=1. Then LW addr 12 with MEM_LAT=2 → valid exactly 2 cycles after accept, val=0xDEADBEEF, and mem_ready low for those 2 cycles.
- mem_valid held high across a busy load → second op accepted only in the first IDLE cycle. No result is lost or duplicated.
- LW to addr 64 (MEM_DEPTH=64) → err=1, val=0. SW to 70 → err=1, memory unchanged (read back all words).
- Assert reset in WAIT, and separately flush in WAIT → no mem_res_valid. mem_ready=1 next cycle. A following load returns correct data (0 after reset).

Source files
------------

// File: rtl/exec_units_pkg.sv
// Shared types and constants for the execute stage: issue entry layout,
// opcode/alu_op encodings and the memory-lane state enum.
package exec_units_pkg;

    localparam int unsigned PKG_XLEN  = 32;
    localparam int unsigned PKG_TAG_W = 4;
    localparam int unsigned OPC_W     = 7;
    localparam int unsigned AOP_W     = 3;

    localparam logic [OPC_W-1:0] OP_R  = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_I  = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_LW = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_SW = 7'b0100011;

    localparam logic [AOP_W-1:0] ALU_ADD  = 3'b000;
    localparam logic [AOP_W-1:0] ALU_SUB  = 3'b001;
    localparam logic [AOP_W-1:0] ALU_XOR  = 3'b010;
    localparam logic [AOP_W-1:0] ALU_SRA  = 3'b011;
    localparam logic [AOP_W-1:0] ALU_ADDI = 3'b000;
    localparam logic [AOP_W-1:0] ALU_ANDI = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic [OPC_W-1:0]     opcode;
        logic [AOP_W-1:0]     alu_op;
        logic [PKG_XLEN-1:0]  source_1;
        logic [PKG_XLEN-1:0]  source_2;
        logic [PKG_XLEN-1:0]  imm;
        logic [PKG_TAG_W-1:0] tag;
    } issue_entry_t;

endpackage

// File: rtl/exec_units_alu_lane.sv
// One single-cycle ALU lane: combinational decode/compute followed by the
// result register.
module alu_lane
    import exec_units_pkg::*;
#(
    parameter int unsigned XLEN  = PKG_XLEN,
    parameter int unsigned TAG_W = PKG_TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             valid,
    input  issue_entry_t     entry,
    output logic             res_valid,
    output logic [XLEN-1:0]  res_val,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err
);

    localparam int unsigned SH_W = $clog2(XLEN);

    logic [XLEN-1:0] src1_c;
    logic [XLEN-1:0] src2_c;
    logic [XLEN-1:0] imm_c;
    logic [XLEN-1:0] val_c;
    logic            err_c;

    assign src1_c = XLEN'(entry.source_1);
    assign src2_c = XLEN'(entry.source_2);
    assign imm_c  = XLEN'(entry.imm);

    // Decode; any unknown opcode/alu_op pair reports err with a zero value.
    always_comb begin
        val_c = '0;
        err_c = 1'b0;
        case (entry.opcode)
            OP_R: begin
                case (entry.alu_op)
                    ALU_ADD: val_c = src1_c + src2_c;
                    ALU_SUB: val_c = src1_c - src2_c;
                    ALU_XOR: val_c = src1_c ^ src2_c;
                    ALU_SRA: val_c = XLEN'($signed(src1_c) >>> src2_c[SH_W-1:0]);
                    default: err_c = 1'b1;
                endcase
            end
            OP_I: begin
                case (entry.alu_op)
                    ALU_ADDI: val_c = src1_c + imm_c;
                    ALU_ANDI: val_c = src1_c & imm_c;
                    default:  err_c = 1'b1;
                endcase
            end
            default: err_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_val   <= '0;
            res_tag   <= '0;
            res_err   <= 1'b0;
        end else begin
            res_valid <= valid && !flush;
            if (valid && !flush) begin
                res_val <= val_c;
                res_tag <= TAG_W'(entry.tag);
                res_err <= err_c;
            end
        end
    end

endmodule

// File: rtl/exec_units.sv
// Execute stage: N_ALU pipelined ALU lanes plus one memory lane that owns the
// data memory and sequences loads/stores with a small handshake FSM.
module exec_units
    import exec_units_pkg::*;
#(
    parameter int unsigned N_ALU     = 2,
    parameter int unsigned XLEN      = PKG_XLEN,
    parameter int unsigned MEM_DEPTH = 64,
    parameter int unsigned MEM_LAT   = 2,
    parameter int unsigned TAG_W     = PKG_TAG_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic [N_ALU-1:0]                alu_valid,
    input  issue_entry_t [N_ALU-1:0]        alu_entry,
    output logic [N_ALU-1:0]                alu_res_valid,
    output logic [N_ALU-1:0][XLEN-1:0]      alu_res_val,
    output logic [N_ALU-1:0][TAG_W-1:0]     alu_res_tag,
    output logic [N_ALU-1:0]                alu_res_err,
    input  logic                            mem_valid,
    output logic                            mem_ready,
    input  issue_entry_t                    mem_entry,
    output logic                            mem_res_valid,
    output logic [XLEN-1:0]                 mem_res_val,
    output logic [TAG_W-1:0]                mem_res_tag,
    output logic                            mem_res_err,
    output logic                            mem_res_store,
    output logic [N_ALU:0]                  busy
);

    localparam int unsigned AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int unsigned CNT_INIT = (MEM_LAT > 1) ? MEM_LAT - 2 : 0;

    for (genvar i = 0; i < int'(N_ALU); i++) begin : g_lane
        alu_lane #(
            .XLEN  (XLEN),
            .TAG_W (TAG_W)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .valid     (alu_valid[i]),
            .entry     (alu_entry[i]),
            .res_valid (alu_res_valid[i]),
            .res_val   (alu_res_val[i]),
            .res_tag   (alu_res_tag[i]),
            .res_err   (alu_res_err[i])
        );
    end

    logic [XLEN-1:0] mem [MEM_DEPTH];
    mem_state_e      state;
    logic [CNT_W-1:0] cnt;

    logic [XLEN-1:0] addr_c;
    logic [AW-1:0]   idx_c;
    logic            in_range_c;
    logic            accept_c;
    logic            unused_alu_op;

    assign addr_c        = XLEN'(mem_entry.source_1) + XLEN'(mem_entry.imm);
    assign idx_c         = addr_c[AW-1:0];
    assign in_range_c    = addr_c < XLEN'(MEM_DEPTH);
    assign mem_ready     = (state == IDLE);
    assign accept_c      = mem_valid && mem_ready && !flush;
    assign busy          = {(state != IDLE), alu_res_valid};
    assign unused_alu_op = ^mem_entry.alu_op;

    // Memory lane: the load snapshot and the store write both happen on the accept edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            mem_res_valid <= 1'b0;
            mem_res_val   <= '0;
            mem_res_tag   <= '0;
            mem_res_err   <= 1'b0;
            mem_res_store <= 1'b0;
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            state         <= IDLE;
            cnt           <= '0;
            mem_res_valid <= 1'b0;
        end else begin
            mem_res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        mem_res_tag   <= TAG_W'(mem_entry.tag);
                        mem_res_val   <= '0;
                        mem_res_err   <= 1'b1;
                        mem_res_store <= 1'b0;
                        state         <= DONE;
                        mem_res_valid <= 1'b1;
                        case (mem_entry.opcode)
                            OP_LW: begin
                                if (in_range_c) begin
                                    mem_res_err <= 1'b0;
                                    mem_res_val <= mem[idx_c];
                                end
                                if (MEM_LAT > 1) begin
                                    state         <= WAIT;
                                    cnt           <= CNT_W'(CNT_INIT);
                                    mem_res_valid <= 1'b0;
                                end
                            end
                            OP_SW: begin
                                mem_res_store <= 1'b1;
                                if (in_range_c) begin
                                    mem_res_err <= 1'b0;
                                    mem_res_val <= addr_c;
                                    mem[idx_c]  <= XLEN'(mem_entry.source_2);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state         <= DONE;
                        mem_res_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_units.sv
// Self-checking bench for exec_units: a cycle-level reference model compared
// every cycle, plus directed vectors with literal expectations.
module tb_exec_units;
    import exec_units_pkg::*;

    localparam int N_ALU     = 2;
    localparam int XLEN      = 32;
    localparam int MEM_DEPTH = 64;
    localparam int MEM_LAT   = 2;
    localparam int TAG_W     = 4;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        flush;
    logic [N_ALU-1:0]            alu_valid;
    issue_entry_t [N_ALU-1:0]    alu_entry;
    logic [N_ALU-1:0]            alu_res_valid;
    logic [N_ALU-1:0][XLEN-1:0]  alu_res_val;
    logic [N_ALU-1:0][TAG_W-1:0] alu_res_tag;
    logic [N_ALU-1:0]            alu_res_err;
    logic                        mem_valid;
    logic                        mem_ready;
    issue_entry_t                mem_entry;
    logic                        mem_res_valid;
    logic [XLEN-1:0]             mem_res_val;
    logic [TAG_W-1:0]            mem_res_tag;
    logic                        mem_res_err;
    logic                        mem_res_store;
    logic [N_ALU:0]              busy;

    always #5 clk = ~clk;

    exec_units #(
        .N_ALU(N_ALU), .XLEN(XLEN), .MEM_DEPTH(MEM_DEPTH), .MEM_LAT(MEM_LAT), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .alu_valid(alu_valid), .alu_entry(alu_entry),
        .alu_res_valid(alu_res_valid), .alu_res_val(alu_res_val),
        .alu_res_tag(alu_res_tag), .alu_res_err(alu_res_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_entry(mem_entry),
        .mem_res_valid(mem_res_valid), .mem_res_val(mem_res_val), .mem_res_tag(mem_res_tag),
        .mem_res_err(mem_res_err), .mem_res_store(mem_res_store), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic issue_entry_t mk(input logic [6:0] op, input logic [2:0] aop,
                                        input logic [31:0] s1, input logic [31:0] s2,
                                        input logic [31:0] imm, input logic [3:0] tag);
        issue_entry_t e;
        e.opcode = op; e.alu_op = aop; e.source_1 = s1; e.source_2 = s2; e.imm = imm; e.tag = tag;
        return e;
    endfunction

    // Reference ALU: {err, value} from signed 32-bit integer arithmetic.
    function automatic logic [32:0] alu_ref(input issue_entry_t e);
        int a;
        int b;
        int im;
        a = e.source_1; b = e.source_2; im = e.imm;
        if (e.opcode == 7'b0110011) begin
            if (e.alu_op == 3'd0) return {1'b0, 32'(a + b)};
            if (e.alu_op == 3'd1) return {1'b0, 32'(a - b)};
            if (e.alu_op == 3'd2) return {1'b0, 32'(a ^ b)};
            if (e.alu_op == 3'd3) return {1'b0, 32'(a >>> e.source_2[4:0])};
        end else if (e.opcode == 7'b0010011) begin
            if (e.alu_op == 3'd0) return {1'b0, 32'(a + im)};
            if (e.alu_op == 3'd4) return {1'b0, 32'(a & im)};
        end
        return {1'b1, 32'h0};
    endfunction

    // Model state; cur counts clock edges, a result is scheduled for a cycle index.
    logic [N_ALU-1:0] m_v;
    logic [31:0]      m_val [N_ALU];
    logic [3:0]       m_tag [N_ALU];
    logic             m_err [N_ALU];
    logic [31:0]      m_mem [MEM_DEPTH];
    bit               pend;
    int               cur = 0;
    int               pend_cur = 0;
    logic [31:0]      p_val;
    logic [3:0]       p_tag;
    logic             p_err;
    logic             p_store;
    bit               m_rdy;
    logic [31:0]      m_addr;
    bit               m_ok;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_v  = '0;
            pend = 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) m_mem[i] = 32'h0;
        end else begin
            m_rdy = !pend || (cur > pend_cur);
            cur++;
            if (flush) begin
                m_v  = '0;
                pend = 1'b0;
            end else begin
                for (int i = 0; i < N_ALU; i++) begin
                    m_v[i] = alu_valid[i];
                    if (alu_valid[i]) begin
                        {m_err[i], m_val[i]} = alu_ref(alu_entry[i]);
                        m_tag[i] = alu_entry[i].tag;
                    end
                end
                if (mem_valid && m_rdy) begin
                    m_addr   = mem_entry.source_1 + mem_entry.imm;
                    m_ok     = m_addr < 32'(MEM_DEPTH);
                    pend     = 1'b1;
                    pend_cur = cur;
                    p_tag    = mem_entry.tag;
                    p_val    = 32'h0;
                    p_err    = 1'b1;
                    p_store  = 1'b0;
                    if (mem_entry.opcode == 7'b0000011) begin
                        pend_cur = cur + MEM_LAT - 1;
                        if (m_ok) begin
                            p_err = 1'b0;
                            p_val = m_mem[m_addr[5:0]];
                        end
                    end else if (mem_entry.opcode == 7'b0100011) begin
                        p_store = 1'b1;
                        if (m_ok) begin
                            p_err = 1'b0;
                            p_val = m_addr;
                            m_mem[m_addr[5:0]] = mem_entry.source_2;
                        end
                    end
                end
            end
        end
    end

    bit chk_en = 1'b0;
    bit exp_rdy;
    bit exp_mv;
    int mem_results = 0;

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            for (int i = 0; i < N_ALU; i++) begin
                chk($sformatf("alu%0d_valid", i), 64'(alu_res_valid[i]), 64'(m_v[i]));
                if (m_v[i]) begin
                    chk($sformatf("alu%0d_val", i), 64'(alu_res_val[i]), 64'(m_val[i]));
                    chk($sformatf("alu%0d_tag", i), 64'(alu_res_tag[i]), 64'(m_tag[i]));
                    chk($sformatf("alu%0d_err", i), 64'(alu_res_err[i]), 64'(m_err[i]));
                end
            end
            exp_rdy = !pend || (cur > pend_cur);
            exp_mv  = pend && (cur == pend_cur);
            chk("mem_ready", 64'(mem_ready), 64'(exp_rdy));
            chk("mem_res_valid", 64'(mem_res_valid), 64'(exp_mv));
            if (exp_mv) begin
                chk("mem_res_val", 64'(mem_res_val), 64'(p_val));
                chk("mem_res_tag", 64'(mem_res_tag), 64'(p_tag));
                chk("mem_res_err", 64'(mem_res_err), 64'(p_err));
                chk("mem_res_store", 64'(mem_res_store), 64'(p_store));
            end
            chk("busy", 64'(busy), 64'({!exp_rdy, m_v}));
            if (mem_res_valid) mem_results++;
        end
    end

    // Offer a memory op, keep mem_valid high until an IDLE cycle takes it, return in the cycle after accept.
    task automatic mem_op(input issue_entry_t e);
        bit was;
        int n;
        n = 0;
        mem_valid = 1'b1;
        mem_entry = e;
        was = 1'b0;
        while (!was) begin
            was = mem_ready;
            @(negedge clk);
            n++;
            if (!was && n > 20) begin
                checks++;
                errors++;
                $display("FAIL mem_accept_timeout actual=not_accepted expected=accepted at %0t", $time);
                was = 1'b1;
            end
        end
        mem_valid = 1'b0;
    endtask

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] I  = 7'b0010011;
    localparam logic [6:0] LW = 7'b0000011;
    localparam logic [6:0] SW = 7'b0100011;

    issue_entry_t vec [8];

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; alu_valid = '0; alu_entry = '0;
        mem_valid = 1'b0; mem_entry = '0;
        repeat (2) @(negedge clk);
        chk("rst_alu_valid", 64'(alu_res_valid), 64'h0);
        chk("rst_alu_val",   64'(alu_res_val), 64'h0);
        chk("rst_alu_tag",   64'(alu_res_tag), 64'h0);
        chk("rst_alu_err",   64'(alu_res_err), 64'h0);
        chk("rst_mem_valid", 64'(mem_res_valid), 64'h0);
        chk("rst_mem_val",   64'(mem_res_val), 64'h0);
        chk("rst_busy",      64'(busy), 64'h0);
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_mem_ready", 64'(mem_ready), 64'h1);

        alu_valid = 2'b01; alu_entry[0] = mk(R, 3'd0, 32'd5, 32'd7, 32'd0, 4'd3);
        @(negedge clk);
        alu_valid = '0;
        chk("add_valid", 64'(alu_res_valid[0]), 64'h1);
        chk("add_val",   64'(alu_res_val[0]), 64'd12);
        chk("add_tag",   64'(alu_res_tag[0]), 64'd3);
        chk("add_err",   64'(alu_res_err[0]), 64'h0);
        @(negedge clk);
        chk("add_once", 64'(alu_res_valid[0]), 64'h0);

        alu_valid = 2'b11;
        alu_entry[0] = mk(R, 3'd3, 32'h8000_0000, 32'd4, 32'd0, 4'd1);
        alu_entry[1] = mk(I, 3'd4, 32'h0000_00FF, 32'd0, 32'h0000_000F, 4'd2);
        @(negedge clk);
        chk("sra_val",  64'(alu_res_val[0]), 64'hF800_0000);
        chk("andi_val", 64'(alu_res_val[1]), 64'h0000_000F);
        alu_valid = 2'b01; alu_entry[0] = mk(7'h7F, 3'd0, 32'd1, 32'd2, 32'd3, 4'd5);
        @(negedge clk);
        alu_valid = '0;
        chk("illegal_err", 64'(alu_res_err[0]), 64'h1);
        chk("illegal_val", 64'(alu_res_val[0]), 64'h0);
        chk("illegal_tag", 64'(alu_res_tag[0]), 64'd5);

        vec[0] = mk(R, 3'd1, 32'd3, 32'd5, 32'd0, 4'd6);
        vec[1] = mk(R, 3'd2, 32'hF0F0_1234, 32'h0FF0_4321, 32'd0, 4'd7);
        vec[2] = mk(I, 3'd0, 32'd100, 32'd0, 32'hFFFF_FFF6, 4'd8);
        vec[3] = mk(R, 3'd4, 32'd1, 32'd1, 32'd0, 4'd9);
        vec[4] = mk(I, 3'd1, 32'd1, 32'd1, 32'd1, 4'd10);
        vec[5] = mk(R, 3'd3, 32'h7FFF_FFFF, 32'd31, 32'd0, 4'd11);
        vec[6] = mk(R, 3'd3, 32'h8000_0010, 32'd33, 32'd0, 4'd12);
        vec[7] = mk(R, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'd13);
        for (int k = 0; k < 8; k++) begin
            alu_valid = 2'b11; alu_entry[0] = vec[k]; alu_entry[1] = vec[7-k];
            @(negedge clk);
            if (k == 0) chk("sub_val", 64'(alu_res_val[0]), 64'hFFFF_FFFE);
        end
        alu_valid = 2'b11; flush = 1'b1;
        @(negedge clk);
        alu_valid = '0; flush = 1'b0;
        chk("alu_flushed", 64'(alu_res_valid), 64'h0);

        mem_op(mk(SW, 3'd0, 32'd10, 32'hDEAD_BEEF, 32'd2, 4'd7));
        chk("sw_valid", 64'(mem_res_valid), 64'h1);
        chk("sw_val",   64'(mem_res_val), 64'd12);
        chk("sw_store", 64'(mem_res_store), 64'h1);
        chk("sw_err",   64'(mem_res_err), 64'h0);
        mem_op(mk(LW, 3'd0, 32'd12, 32'd0, 32'd0, 4'd8));
        chk("lw_wait_valid", 64'(mem_res_valid), 64'h0);
        chk("lw_wait_ready", 64'(mem_ready), 64'h0);
        @(negedge clk);
        chk("lw_valid", 64'(mem_res_valid), 64'h1);
        chk("lw_val",   64'(mem_res_val), 64'hDEAD_BEEF);
        chk("lw_ready", 64'(mem_ready), 64'h0);
        @(negedge clk);
        chk("lw_idle_ready", 64'(mem_ready), 64'h1);

        mem_op(mk(LW, 3'd0, 32'd12, 32'd0, 32'd0, 4'd9));
        mem_op(mk(LW, 3'd0, 32'hFFFF_FFFF, 32'd0, 32'd1, 4'd10));
        mem_op(mk(SW, 3'd0, 32'hFFFF_FFFF, 32'h1234_5678, 32'd6, 4'd11));
        mem_op(mk(7'h33, 3'd0, 32'd1, 32'd2, 32'd3, 4'd12));
        mem_op(mk(LW, 3'd0, 32'd5, 32'd0, 32'd0, 4'd13));
        repeat (3) @(negedge clk);
        chk("mem_result_count", 64'(mem_results), 64'd7);

        mem_op(mk(LW, 3'd0, 32'd60, 32'd0, 32'd4, 4'd1));
        @(negedge clk);
        chk("oor_lw_err", 64'(mem_res_err), 64'h1);
        chk("oor_lw_val", 64'(mem_res_val), 64'h0);
        mem_op(mk(SW, 3'd0, 32'd70, 32'hAAAA_5555, 32'd0, 4'd2));
        chk("oor_sw_err", 64'(mem_res_err), 64'h1);
        for (int a = 0; a < MEM_DEPTH; a++) begin
            mem_op(mk(LW, 3'd0, 32'(a), 32'd0, 32'd0, 4'(a)));
        end
        repeat (3) @(negedge clk);

        mem_valid = 1'b1; mem_entry = mk(SW, 3'd0, 32'd20, 32'd55, 32'd0, 4'd3); flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; mem_valid = 1'b0;
        chk("flush_blocks_ready", 64'(mem_ready), 64'h1);
        @(negedge clk);
        chk("flush_blocks_valid", 64'(mem_res_valid), 64'h0);
        mem_op(mk(LW, 3'd0, 32'd20, 32'd0, 32'd0, 4'd4));
        @(negedge clk);
        chk("flush_blocks_write", 64'(mem_res_val), 64'h0);

        mem_op(mk(LW, 3'd0, 32'd12, 32'd0, 32'd0, 4'd3));
        #2 reset = 1'b1;
        @(negedge clk);
        chk("rst_wait_valid", 64'(mem_res_valid), 64'h0);
        chk("rst_wait_busy",  64'(busy), 64'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_wait_ready", 64'(mem_ready), 64'h1);
        chk("rst_wait_novalid", 64'(mem_res_valid), 64'h0);
        mem_op(mk(LW, 3'd0, 32'd12, 32'd0, 32'd0, 4'd4));
        @(negedge clk);
        chk("rst_ld_valid", 64'(mem_res_valid), 64'h1);
        chk("rst_ld_val",   64'(mem_res_val), 64'h0);

        mem_op(mk(SW, 3'd0, 32'd12, 32'h0000_CAFE, 32'd0, 4'd5));
        mem_op(mk(LW, 3'd0, 32'd12, 32'd0, 32'd0, 4'd6));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_wait_valid", 64'(mem_res_valid), 64'h0);
        chk("flush_wait_ready", 64'(mem_ready), 64'h1);
        @(negedge clk);
        chk("flush_wait_novalid", 64'(mem_res_valid), 64'h0);
        mem_op(mk(LW, 3'd0, 32'd12, 32'd0, 32'd0, 4'd7));
        @(negedge clk);
        chk("flush_keeps_store", 64'(mem_res_val), 64'h0000_CAFE);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
